// File: rtl/arb_pkg.sv
// Shared types, widths and the round-robin search used by the four-way arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request bit found searching ptr, ptr+1, ... with wrap; 0 if none.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/onehot_enc4.sv
// Four-bit one-hot to binary index; zero or non-one-hot input encodes to 0.
module onehot_enc4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        idx_c = '0;
        case (onehot)
            4'b0010: idx_c = 2'd1;
            4'b0100: idx_c = 2'd2;
            4'b1000: idx_c = 2'd3;
            default: idx_c = 2'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index
// and a hold limit that forces re-arbitration while others are waiting.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  ptr_q,       ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [N_REQ-1:0]  gnt_q,       gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]  win_c;
    logic              others_c;

    assign win_c    = rr_pick(req, ptr_q);
    assign others_c = |(req & ~gnt_q);

    // Next-state, pointer, hold counter and next grant vector.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (en && (req != '0)) begin
                    state_d    = GRANT;
                    gnt_d      = N_REQ'(1) << win_c;
                    ptr_d      = win_c + IDX_W'(1);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q] || !en) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if ((MAX_HOLD != 0) && others_c) begin
                    // Saturating count; reaching the limit hands the resource back.
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q
                                                          : hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_d == HOLD_MAX) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    onehot_enc4 u_enc (
        .onehot (gnt_d),
        .idx_c  (gnt_idx_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: vector table for rotation and enable behaviour,
// hand sequences for hold timeout, sole-owner hold and asynchronous reset.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int checks;
    int errors;

    rr_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       en;
        logic [3:0] exp_gnt;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] ei);
        logic ev;
        ev = |eg;
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
                     name, gnt, gnt_idx, gnt_valid, eg, ei, ev);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        req    = 4'b0000;

        // Rotation with all requesting, then wrap past a missing requester, then enable.
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1110, 1'b1, 4'b0000, 2'd0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
        vecs[3]  = '{4'b1101, 1'b1, 4'b0000, 2'd0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 2'd2};
        vecs[5]  = '{4'b1011, 1'b1, 4'b0000, 2'd0};
        vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        vecs[7]  = '{4'b0111, 1'b1, 4'b0000, 2'd0};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        vecs[9]  = '{4'b1110, 1'b1, 4'b0000, 2'd0};
        vecs[10] = '{4'b0010, 1'b1, 4'b0010, 2'd1};
        vecs[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[12] = '{4'b1011, 1'b1, 4'b1000, 2'd3};
        vecs[13] = '{4'b0011, 1'b1, 4'b0000, 2'd0};
        vecs[14] = '{4'b1011, 1'b1, 4'b0001, 2'd0};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[16] = '{4'b0001, 1'b0, 4'b0000, 2'd0};
        vecs[17] = '{4'b0001, 1'b1, 4'b0001, 2'd0};
        vecs[18] = '{4'b0001, 1'b0, 4'b0000, 2'd0};
        vecs[19] = '{4'b0001, 1'b0, 4'b0000, 2'd0};
        vecs[20] = '{4'b0001, 1'b1, 4'b0001, 2'd0};
        vecs[21] = '{4'b0000, 1'b1, 4'b0000, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'b0000, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", 4'b0000, 2'd0);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].req, vecs[i].en);
            chk($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx);
        end

        // ptr is 1 here; grant 3 so the pointer returns to 0.
        step(4'b1000, 1'b1);
        chk("to_ptr0_grant", 4'b1000, 2'd3);
        step(4'b0000, 1'b1);
        chk("to_ptr0_release", 4'b0000, 2'd0);

        // Owner 0 holds with requester 2 waiting: 8 grant cycles, 1 idle, then 2.
        for (int c = 0; c < 8; c++) begin
            step(4'b0101, 1'b1);
            chk($sformatf("hold_c%0d", c), 4'b0001, 2'd0);
        end
        step(4'b0101, 1'b1);
        chk("timeout_idle", 4'b0000, 2'd0);
        step(4'b0101, 1'b1);
        chk("timeout_next", 4'b0100, 2'd2);
        step(4'b0000, 1'b1);
        chk("timeout_release", 4'b0000, 2'd0);

        // Sole requester 1 is never timed out (ptr=3 so search 3,0,1).
        for (int c = 0; c < 20; c++) begin
            step(4'b0010, 1'b1);
            chk($sformatf("sole_c%0d", c), 4'b0010, 2'd1);
        end
        step(4'b0000, 1'b1);
        chk("sole_release", 4'b0000, 2'd0);

        // Grant 2 (ptr becomes 3), then asynchronous reset between edges.
        step(4'b0100, 1'b1);
        chk("pre_reset_grant", 4'b0100, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // ptr back at 0 picks 2 from 1100; a stale ptr of 3 would pick 3.
        step(4'b1100, 1'b1);
        chk("reset_ptr0", 4'b0100, 2'd2);
        step(4'b0000, 1'b1);
        chk("reset_ptr0_release", 4'b0000, 2'd0);
        step(4'b1000, 1'b1);
        chk("after_reset_req3", 4'b1000, 2'd3);
        step(4'b0000, 1'b1);
        chk("final_release", 4'b0000, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares a single downstream resource, such as a 4-to-2 encoded select path, between four clients. It samples a 4-bit request vector, issues a registered one-hot grant plus its 2-bit encoded index, and holds the grant until the owner releases it or a hold limit expires. It sits between the requesting units and the shared resource's select/enable inputs.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a grant may be held while at least one other requester is waiting. 0 means unlimited.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  arbiter enable. 0 means no new grants, and any current grant is revoked.
- `req`  in  4  request vector, bit i = requester i. Level-sensitive; held high for the whole transaction.
- `gnt`  out  4  one-hot grant, registered. All zeros when no grant is active.
- `gnt_idx`  out  2  binary index of the granted requester (0..3). 2'b00 when `gnt_valid`=0. Never X.
- `gnt_valid`  out  1  high while a grant is active; equals `|gnt`.

## Operation
- FSM with two states: IDLE and GRANT.
- Round-robin pointer `ptr` (2 bits) holds the highest-priority requester for the next arbitration.
- **IDLE**
  - If `en`=1 and `req`≠0: select the first set bit of `req` searching ptr, ptr+1, … with wrap 3→0.
  - Load `gnt`/`gnt_idx`, set `gnt_valid`, go to GRANT.
  - Set `ptr` to (winner+1) mod 4 and clear `hold_cnt`.
  - Otherwise stay in IDLE with outputs zero.
- **GRANT**, owner = current `gnt_idx`
  - Owner's `req` bit low → release: next edge goes to IDLE and clears outputs.
  - `en` low → revoke: same as release.
  - Otherwise, if `MAX_HOLD`≠0 and any non-owner `req` bit is high, increment `hold_cnt`.
  - When `hold_cnt` reaches `MAX_HOLD`, force a revoke: go to IDLE. `ptr` already points past the owner, so the owner has lowest priority at the next arbitration.
  - If no other requester is waiting, `hold_cnt` holds its value and does not reset.
- Requests from non-owners during GRANT are ignored until the FSM returns to IDLE.
- Release, revoke and timeout in the same cycle all produce the same result: IDLE.
- Width rule: `hold_cnt` width is $clog2(MAX_HOLD+1), minimum 1. It saturates and never wraps.
- Invariant: `gnt` is always one-hot or zero, and `gnt_idx` is the encoding of `gnt`.

## Timing
- Reset values while `rst_n`=0, applied asynchronously:
  - state = IDLE, `ptr`=0, `hold_cnt`=0
  - `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_valid`=0
- Reset mid-GRANT drops the grant immediately, with no handshake. After reset, requester 0 has top priority.
- Grant latency: request sampled at edge k in IDLE → `gnt` visible after edge k.
- Release latency: owner `req` low sampled at edge k → `gnt`=0 after edge k.
- Minimum gap between successive grants is 1 cycle in IDLE, which is also the re-arbitration cycle.
- Timeout: with others waiting from grant onward, the grant lasts exactly `MAX_HOLD` cycles, followed by 1 idle cycle.
- All outputs are registered; there is no combinational path from `req` or `en` to any output.

## Structure
- Package `arb_pkg`:
  - `N_REQ`=4 and `IDX_W`=2
  - `state_t` enum {IDLE, GRANT}
  - function `rr_pick(req, ptr)` returning the winner index
- Sub-module `onehot_enc4`: 4-bit one-hot to 2-bit index, outputs 00 on zero or illegal input. It drives `gnt_idx` from the next-state `gnt` before the output register.

## Test plan
- Reset, then `req`=4'b1111 with `en`=1 → grants cycle in order 0,1,2,3,0 as each owner drops `req` for one cycle. `gnt_idx` follows 00,01,10,11,00.
- `ptr`=2 (after granting 1), `req`=4'b1011 → `gnt`=4'b1000 and `gnt_idx`=11; then wrap to requester 0.
- `MAX_HOLD`=8, owner 0 holds `req` with `req`[2]=1 → `gnt` drops after 8 grant cycles; 1 idle cycle; then `gnt`=4'b0100.
- Sole requester 1 holds for 20 cycles → no timeout, `gnt`=4'b0010 throughout.
- `en`→0 during a grant → `gnt`=0 after the next edge; `req`=4'b0001 with `en`=0 → no grant.
- `rst_n` pulsed low mid-grant between clock edges → outputs 0 immediately; after release, `req`=4'b1000 → `gnt`=4'b1000 after 1 edge.
